sopc_v3_sense_in: RTL and testbench

SOPC_V3_SENSE_IN -- requirements
Module: sopc_v3_sense_in

---
 rtl/sopc_v3_sense_in.sv | 102 ++++++++++
 tb/tb_sopc_v3_sense_in.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sopc_v3_sense_in.sv
// Debounced parallel input port with per-bit edge capture and maskable interrupt,
// exposed as a four-word Avalon-MM slave.
module sopc_v3_sense_in #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]      sync1;
    logic [WIDTH-1:0]      sync2;
    logic [WIDTH-1:0]      stable;
    logic [WIDTH-1:0]      stable_next;
    logic [WIDTH-1:0][7:0] cnt;
    logic [WIDTH-1:0][7:0] cnt_next;
    logic [WIDTH-1:0]      edge_sel;
    logic [WIDTH-1:0]      irqmask;
    logic [WIDTH-1:0]      edgecapture;
    logic [WIDTH-1:0]      edge_event;
    logic [WIDTH-1:0]      w1c_clear;
    logic [WIDTH-1:0]      wdata_bits;
    logic                  wr_en;

    assign wr_en      = chipselect & ~write_n;
    assign wdata_bits = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_writedata;
            assign unused_writedata = |writedata[31:WIDTH];
        end
    endgenerate

    // A bit is accepted only after its synchronized value has differed from
    // the debounced value for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        stable_next = stable;
        cnt_next    = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_next[i] = sync2[i];
                cnt_next[i]    = '0;
            end else begin
                cnt_next[i] = cnt[i] + 8'd1;
            end
        end
    end

    assign edge_event = (~edge_sel & ~stable &  stable_next)
                      | ( edge_sel &  stable & ~stable_next);
    assign w1c_clear  = (wr_en && address == 2'd3) ? wdata_bits : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            cnt         <= '0;
            edge_sel    <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            stable      <= stable_next;
            cnt         <= cnt_next;
            // OR-ing the event in after the clear lets a new capture win over W1C.
            edgecapture <= (edgecapture & ~w1c_clear) | edge_event;
            if (wr_en && address == 2'd1) begin
                edge_sel <= wdata_bits;
            end
            if (wr_en && address == 2'd2) begin
                irqmask <= wdata_bits;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd1:    readdata[WIDTH-1:0] = edge_sel;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            default: readdata[WIDTH-1:0] = edgecapture;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_sopc_v3_sense_in.sv
// Scoreboard bench for sopc_v3_sense_in: directed scenarios followed by random
// traffic, all predicted by a window-based behavioural model of the port.
module tb_sopc_v3_sense_in;

    localparam int WIDTH = 16;
    localparam int DEB   = 4;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    sopc_v3_sense_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [WIDTH-1:0] m_sync1, m_sync2, m_stable, m_esel, m_mask, m_ec;
    logic [WIDTH-1:0] m_hist[$];

    task automatic modelReset();
        m_sync1  = '0;
        m_sync2  = '0;
        m_stable = '0;
        m_esel   = '0;
        m_mask   = '0;
        m_ec     = '0;
        m_hist   = {};
        repeat (DEB) m_hist.push_back('0);
    endtask

    // A bit flips when each of the last DEB synchronized samples disagrees with it.
    task automatic modelStep();
        logic [WIDTH-1:0] all_diff, new_stable, ev, clr;
        m_hist.push_front(m_sync2);
        while (m_hist.size() > DEB) void'(m_hist.pop_back());
        all_diff = '1;
        foreach (m_hist[j]) all_diff &= (m_hist[j] ^ m_stable);
        new_stable = m_stable ^ all_diff;
        ev = (~m_esel & ~m_stable & new_stable) | (m_esel & m_stable & ~new_stable);
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        m_ec = (m_ec & ~clr) | ev;
        if (chipselect && !write_n && address == 2'd1) m_esel = writedata[WIDTH-1:0];
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
        m_stable = new_stable;
        m_sync2  = m_sync1;
        m_sync1  = in_port;
    endtask

    function automatic logic [31:0] expRead(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0:    r[WIDTH-1:0] = m_stable;
            2'd1:    r[WIDTH-1:0] = m_esel;
            2'd2:    r[WIDTH-1:0] = m_mask;
            default: r[WIDTH-1:0] = m_ec;
        endcase
        return r;
    endfunction

    // Advance the model over the edge just taken, then drive the next cycle's inputs.
    task automatic applyStimulus(input logic rst_v, input logic [WIDTH-1:0] in_v,
                                 input logic [1:0] addr_v, input logic wr_v,
                                 input logic [31:0] wd_v);
        exp_t e;
        @(posedge clk);
        #1;
        if (reset_n) modelStep();
        reset_n = rst_v;
        if (!rst_v) modelReset();
        in_port   = in_v;
        address   = addr_v;
        writedata = wd_v;
        if (wr_v) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
            chipselect = 1'b0;
            write_n    = 1'($urandom_range(0, 1));
        end else begin
            chipselect = 1'b1;
            write_n    = 1'b1;
        end
        e.addr = addr_v;
        e.rd   = expRead(addr_v);
        e.irq  = |(m_ec & m_mask);
        sb.push_back(e);
    endtask

    task automatic holdIn(input int n, input logic [WIDTH-1:0] v, input logic [1:0] a);
        repeat (n) applyStimulus(1'b1, v, a, 1'b0, 32'h0);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (readdata !== e.rd || irq !== e.irq) begin
            miscompares++;
            $display("[TB] FAIL read addr=%0d: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                     e.addr, readdata, irq, e.rd, e.irq);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        logic [WIDTH-1:0] rin;
        reset_n    = 1'b0;
        in_port    = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        modelReset();

        // Reset, then 0x0005 held: stable and capture appear after the debounce.
        repeat (3) applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 32'h0);
        applyStimulus(1'b1, 16'h0005, 2'd0, 1'b0, 32'h0);
        holdIn(8, 16'h0005, 2'd0);
        holdIn(2, 16'h0005, 2'd3);

        // Three-clock glitch on bit 2 is rejected.
        applyStimulus(1'b1, 16'h0003 ^ 16'h0006, 2'd3, 1'b1, 32'hFFFF_FFFF);
        holdIn(3, 16'h0001, 2'd0);
        holdIn(4, 16'h0005, 2'd0);
        holdIn(4, 16'h0005, 2'd3);
        holdIn(3, 16'h0001, 2'd0);
        holdIn(8, 16'h0001, 2'd3);

        // Masked bit-0 rising edge drives irq; W1C drops it.
        applyStimulus(1'b1, 16'h0001, 2'd2, 1'b1, 32'hFFFF_0001);
        holdIn(8, 16'h0000, 2'd3);
        holdIn(8, 16'h0001, 2'd3);
        applyStimulus(1'b1, 16'h0001, 2'd3, 1'b1, 32'h0000_0001);
        holdIn(3, 16'h0001, 2'd3);

        // Falling-edge selection on bit 3.
        applyStimulus(1'b1, 16'h0001, 2'd1, 1'b1, 32'h0000_0008);
        holdIn(8, 16'h0009, 2'd3);
        holdIn(8, 16'h0001, 2'd3);
        holdIn(2, 16'h0001, 2'd1);

        // W1C of bit 0 in the same clock as a new bit-0 capture: set wins.
        applyStimulus(1'b1, 16'h0000, 2'd3, 1'b1, 32'h0000_FFFF);
        holdIn(8, 16'h0000, 2'd3);
        holdIn(5, 16'h0001, 2'd3);
        applyStimulus(1'b1, 16'h0001, 2'd3, 1'b1, 32'h0000_0001);
        holdIn(3, 16'h0001, 2'd3);

        // Reset lands mid-debounce, input held high across it.
        holdIn(8, 16'h0000, 2'd0);
        holdIn(4, 16'h0005, 2'd0);
        applyStimulus(1'b0, 16'h0005, 2'd3, 1'b0, 32'h0);
        applyStimulus(1'b0, 16'h0005, 2'd0, 1'b0, 32'h0);
        applyStimulus(1'b1, 16'h0005, 2'd0, 1'b0, 32'h0);
        holdIn(7, 16'h0005, 2'd0);
        holdIn(2, 16'h0005, 2'd3);
        applyStimulus(1'b1, 16'h0005, 2'd2, 1'b1, 32'h0000_0004);
        holdIn(2, 16'h0005, 2'd3);

        // Random traffic: sparse input toggles, random bus writes, rare resets.
        rin = 16'h0005;
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            if (n % 40 < 20) rin ^= WIDTH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 299) == 0) begin
                applyStimulus(1'b0, rin, a, 1'b0, 32'h0);
            end else if ($urandom_range(0, 5) == 0) begin
                applyStimulus(1'b1, rin, a, 1'b1, $urandom);
            end else begin
                applyStimulus(1'b1, rin, a, 1'b0, $urandom);
            end
        end

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
